// File: rtl/update_line_packer.sv
// update_line_packer
//
// Packs sorted 8-lane batches (valid words in the highest-indexed lanes) into
// dense 8-word lines. Valid words are appended to a 15-entry accumulator; a
// full line is emitted whenever 8 or more words are held. On end-of-input the
// remainder is flushed as a final partial line. If that remainder exceeds 8,
// the flush takes a second cycle in the FLUSH state.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   word_in0..7, valid_in0..7 sorted batch words and per-lane valid bits
//   word_in_valid             batch qualifier
//   last_input_in             end-of-input marker (accepted with or without a batch)
//   control_in                tag latched with each accepted batch / last-only cycle
//   line_out0..7              packed line, oldest word in lane 0, unused lanes 0
//   line_valid                one-cycle strobe for line_out/line_count/line_last
//   line_count, line_last     words in the line (0..8), final-line flag
//   control_out               latched control tag
//   fill_level                registered accumulator occupancy
//   format_err, overflow_err  sticky error flags (cleared only by rst)
module update_line_packer #(
  parameter int W     = 32,
  parameter int LANES = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] word_in0,
  input  logic [W-1:0] word_in1,
  input  logic [W-1:0] word_in2,
  input  logic [W-1:0] word_in3,
  input  logic [W-1:0] word_in4,
  input  logic [W-1:0] word_in5,
  input  logic [W-1:0] word_in6,
  input  logic [W-1:0] word_in7,
  input  logic         valid_in0,
  input  logic         valid_in1,
  input  logic         valid_in2,
  input  logic         valid_in3,
  input  logic         valid_in4,
  input  logic         valid_in5,
  input  logic         valid_in6,
  input  logic         valid_in7,
  input  logic         word_in_valid,
  input  logic         last_input_in,
  input  logic [1:0]   control_in,
  output logic [W-1:0] line_out0,
  output logic [W-1:0] line_out1,
  output logic [W-1:0] line_out2,
  output logic [W-1:0] line_out3,
  output logic [W-1:0] line_out4,
  output logic [W-1:0] line_out5,
  output logic [W-1:0] line_out6,
  output logic [W-1:0] line_out7,
  output logic         line_valid,
  output logic [3:0]   line_count,
  output logic         line_last,
  output logic [1:0]   control_out,
  output logic [3:0]   fill_level,
  output logic         format_err,
  output logic         overflow_err
);

  localparam int DEPTH = 2 * LANES - 1;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t state_reg, state_next;

  logic [W-1:0] words     [LANES];
  logic [W-1:0] acc_reg   [DEPTH];
  logic [W-1:0] acc_next  [DEPTH];
  logic [W-1:0] merged    [DEPTH];
  logic [W-1:0] shifted   [DEPTH];
  logic [W-1:0] line_reg  [LANES];
  logic [W-1:0] emit_words[LANES];
  logic [3:0]   fill_reg, fill_next;
  logic [7:0]   mask, top_mask;
  logic [3:0]   n, n_eff, nf;
  logic         format_bad;
  logic         emit, emit_last;
  logic [3:0]   emit_count;

  assign words[0] = word_in0;
  assign words[1] = word_in1;
  assign words[2] = word_in2;
  assign words[3] = word_in3;
  assign words[4] = word_in4;
  assign words[5] = word_in5;
  assign words[6] = word_in6;
  assign words[7] = word_in7;
  assign mask = {valid_in7, valid_in6, valid_in5, valid_in4,
                 valid_in3, valid_in2, valid_in1, valid_in0};

  always_comb begin
    n = '0;
    for (int i = 0; i < LANES; i++) n = n + {3'b000, mask[i]};
  end

  assign n_eff      = word_in_valid ? n : 4'd0;
  assign top_mask   = ~(8'hFF >> n);          // the only legal mask for this popcount
  assign format_bad = word_in_valid && (mask != top_mask);
  // fill is at most 7 whenever a batch is accepted, so nf fits in 4 bits
  assign nf         = fill_reg + n_eff;

  // merged = held words followed by lanes 8-n..7 of the batch, zero beyond nf
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_merge
    logic [3:0] pos, off;
    always_comb begin
      pos        = 4'(gi);
      off        = pos - fill_reg;
      merged[gi] = '0;
      if (pos < fill_reg)
        merged[gi] = acc_reg[gi];
      else if (off < n_eff)
        merged[gi] = words[3'(off + 4'd8 - n_eff)];
    end
  end

  // remainder after a full line leaves: move entries 8..14 down to 0..6
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_shift
    if (gi < DEPTH - LANES) begin : g_hi
      assign shifted[gi] = merged[gi + LANES];
    end else begin : g_zero
      assign shifted[gi] = '0;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= RUN;
    else     state_reg <= state_next;
  end

  // next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (last_input_in && nf > 4'd8) state_next = FLUSH;
      FLUSH:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // output / datapath logic
  always_comb begin
    acc_next   = acc_reg;
    fill_next  = fill_reg;
    emit       = 1'b0;
    emit_count = 4'd0;
    emit_last  = 1'b0;
    for (int i = 0; i < LANES; i++) emit_words[i] = '0;
    if (state_reg == FLUSH) begin
      // entries at and above fill are kept zero, so lanes >= count come out 0
      emit       = 1'b1;
      emit_count = fill_reg;
      emit_last  = 1'b1;
      fill_next  = 4'd0;
      for (int i = 0; i < LANES; i++) emit_words[i] = acc_reg[i];
      for (int i = 0; i < DEPTH; i++) acc_next[i] = '0;
    end else if (last_input_in && nf <= 4'd8) begin
      emit       = 1'b1;
      emit_count = nf;
      emit_last  = 1'b1;
      fill_next  = 4'd0;
      for (int i = 0; i < LANES; i++) emit_words[i] = merged[i];
      for (int i = 0; i < DEPTH; i++) acc_next[i] = '0;
    end else if (nf >= 4'd8) begin
      // full line; with last_input_in this is the first half of a flush
      emit       = 1'b1;
      emit_count = 4'd8;
      fill_next  = nf - 4'd8;
      for (int i = 0; i < LANES; i++) emit_words[i] = merged[i];
      acc_next   = shifted;
    end else begin
      acc_next  = merged;
      fill_next = nf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) acc_reg[i] <= '0;
      for (int i = 0; i < LANES; i++) line_reg[i] <= '0;
      fill_reg     <= 4'd0;
      line_valid   <= 1'b0;
      line_count   <= 4'd0;
      line_last    <= 1'b0;
      control_out  <= 2'd0;
      format_err   <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      acc_reg    <= acc_next;
      fill_reg   <= fill_next;
      line_valid <= emit;
      if (emit) begin
        line_reg   <= emit_words;
        line_count <= emit_count;
        line_last  <= emit_last;
      end
      if (state_reg == RUN && (word_in_valid || last_input_in)) control_out <= control_in;
      if (state_reg == RUN && format_bad) format_err <= 1'b1;
      if (state_reg == FLUSH && word_in_valid) overflow_err <= 1'b1;
    end
  end

  assign fill_level = fill_reg;
  assign line_out0  = line_reg[0];
  assign line_out1  = line_reg[1];
  assign line_out2  = line_reg[2];
  assign line_out3  = line_reg[3];
  assign line_out4  = line_reg[4];
  assign line_out5  = line_reg[5];
  assign line_out6  = line_reg[6];
  assign line_out7  = line_reg[7];

endmodule

// File: tb/tb_update_line_packer.sv
module tb_update_line_packer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] win [8];
  logic [7:0]   vin;
  logic         wiv, lastin;
  logic [1:0]   ctrl;
  logic [W-1:0] lout[8];
  logic         line_valid, line_last, format_err, overflow_err;
  logic [3:0]   line_count, fill_level;
  logic [1:0]   control_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  update_line_packer #(.W(W), .LANES(8)) dut (
    .clk(clk), .rst(rst),
    .word_in0(win[0]), .word_in1(win[1]), .word_in2(win[2]), .word_in3(win[3]),
    .word_in4(win[4]), .word_in5(win[5]), .word_in6(win[6]), .word_in7(win[7]),
    .valid_in0(vin[0]), .valid_in1(vin[1]), .valid_in2(vin[2]), .valid_in3(vin[3]),
    .valid_in4(vin[4]), .valid_in5(vin[5]), .valid_in6(vin[6]), .valid_in7(vin[7]),
    .word_in_valid(wiv), .last_input_in(lastin), .control_in(ctrl),
    .line_out0(lout[0]), .line_out1(lout[1]), .line_out2(lout[2]), .line_out3(lout[3]),
    .line_out4(lout[4]), .line_out5(lout[5]), .line_out6(lout[6]), .line_out7(lout[7]),
    .line_valid(line_valid), .line_count(line_count), .line_last(line_last),
    .control_out(control_out), .fill_level(fill_level),
    .format_err(format_err), .overflow_err(overflow_err)
  );

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endfunction

  function automatic int popc(logic [7:0] m);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(m[i]);
    return c;
  endfunction

  // ---------------- behavioural model: a FIFO of words ----------------
  logic [W-1:0] mq[$];
  bit           m_flush, started;
  logic [W-1:0] e_line[8];
  bit           e_valid, e_last, e_fmt, e_ovf;
  int           e_count, e_fill;
  logic [1:0]   e_ctrl;

  task automatic model_emit(int cnt, bit lst);
    e_valid = 1;
    e_count = cnt;
    e_last  = lst;
    for (int i = 0; i < 8; i++) begin
      if (i < cnt) e_line[i] = mq.pop_front();
      else         e_line[i] = '0;
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_flush = 0; e_valid = 0; e_count = 0; e_last = 0;
      e_ctrl = 0; e_fmt = 0; e_ovf = 0; e_fill = 0;
      for (int i = 0; i < 8; i++) e_line[i] = '0;
      started = 1;
    end else if (started) begin
      e_valid = 0;
      if (m_flush) begin
        if (wiv) e_ovf = 1;
        model_emit(mq.size(), 1);
        m_flush = 0;
      end else begin
        if (wiv) begin
          int nn;
          nn = popc(vin);
          for (int i = 8 - nn; i < 8; i++) mq.push_back(win[i]);
          for (int i = 0; i < 8; i++) if (vin[i] != (i >= 8 - nn)) e_fmt = 1;
        end
        if (wiv || lastin) e_ctrl = ctrl;
        if (lastin) begin
          if (mq.size() <= 8) model_emit(mq.size(), 1);
          else begin
            model_emit(8, 0);
            m_flush = 1;
          end
        end else if (mq.size() >= 8) begin
          model_emit(8, 0);
        end
      end
      e_fill = mq.size();
    end
  end

  // compare process: every cycle once the model is live
  always @(negedge clk) begin
    if (started) begin
      chk("line_valid", line_valid, e_valid);
      chk("line_count", line_count, e_count);
      chk("line_last", line_last, e_last);
      chk("control_out", control_out, e_ctrl);
      chk("fill_level", fill_level, e_fill);
      chk("format_err", format_err, e_fmt);
      chk("overflow_err", overflow_err, e_ovf);
      for (int i = 0; i < 8; i++) chk($sformatf("line_out%0d", i), lout[i], e_line[i]);
    end
  end

  // lane i carries base + (i - first valid lane), so taken words run base, base+1, ...
  task automatic send(logic [7:0] m, int base, bit wv, bit lst, logic [1:0] c);
    int first;
    first = 8 - popc(m);
    vin = m; wiv = wv; lastin = lst; ctrl = c;
    for (int i = 0; i < 8; i++) win[i] = W'(base + i - first);
    @(posedge clk); #3;
    wiv = 0; lastin = 0;
  endtask

  initial begin
    logic [7:0] ff;
    ff = 8'hFF;
    rst = 1; wiv = 0; lastin = 0; vin = 0; ctrl = 0;
    for (int i = 0; i < 8; i++) win[i] = '0;
    repeat (2) @(posedge clk);
    #3 rst = 0;
    chk("reset_valid", line_valid, 0);
    chk("reset_fill", fill_level, 0);

    // accumulation 3+3+3
    send(8'hE0, 1, 1, 0, 2'd1);
    chk("acc1_valid", line_valid, 0);
    send(8'hE0, 4, 1, 0, 2'd1);
    chk("acc2_valid", line_valid, 0);
    send(8'hE0, 7, 1, 0, 2'd1);
    chk("acc3_valid", line_valid, 1);
    chk("acc3_count", line_count, 8);
    chk("acc3_fill", fill_level, 1);
    for (int i = 0; i < 8; i++) chk($sformatf("acc3_lane%0d", i), lout[i], 64'(i + 1));
    $display("txn accumulate: count=%0d fill=%0d", line_count, fill_level);

    // reset with traffic pending
    vin = 8'hFF; wiv = 1; rst = 1;
    @(posedge clk); #3;
    rst = 0; wiv = 0;
    chk("rst_valid", line_valid, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_count", line_count, 0);
    chk("rst_lane0", lout[0], 0);

    // back-to-back full batches
    send(8'hFF, 100, 1, 0, 2'd2);
    chk("full1_count", line_count, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("full1_lane%0d", i), lout[i], 64'(100 + i));
    send(8'hFF, 200, 1, 0, 2'd2);
    chk("full2_valid", line_valid, 1);
    for (int i = 0; i < 8; i++) chk($sformatf("full2_lane%0d", i), lout[i], 64'(200 + i));
    $display("txn full lines: fill=%0d", fill_level);

    // flush of 12 words, with a batch arriving during FLUSH
    send(8'hF8, 1, 1, 0, 2'd3);
    chk("fl_pre_fill", fill_level, 5);
    send(8'hFE, 6, 1, 1, 2'd3);
    chk("fl1_count", line_count, 8);
    chk("fl1_last", line_last, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("fl1_lane%0d", i), lout[i], 64'(i + 1));
    send(8'hFF, 500, 1, 0, 2'd0);
    chk("fl2_valid", line_valid, 1);
    chk("fl2_count", line_count, 4);
    chk("fl2_last", line_last, 1);
    chk("fl2_ovf", overflow_err, 1);
    chk("fl2_ctrl", control_out, 3);
    for (int i = 0; i < 8; i++) chk($sformatf("fl2_lane%0d", i), lout[i], (i < 4) ? 64'(i + 9) : 64'd0);
    send(8'h00, 0, 0, 0, 2'd0);
    chk("fl_post_fill", fill_level, 0);
    chk("fl_post_valid", line_valid, 0);
    $display("txn flush: overflow_err=%0d", overflow_err);

    // empty end
    send(8'h00, 0, 0, 1, 2'd0);
    chk("empty_valid", line_valid, 1);
    chk("empty_count", line_count, 0);
    chk("empty_last", line_last, 1);
    $display("txn empty end: count=%0d last=%0d", line_count, line_last);

    // non-contiguous mask: lanes 6..7 taken
    send(8'b0101_0000, 32'h66, 1, 0, 2'd2);
    chk("fmt_err", format_err, 1);
    chk("fmt_fill", fill_level, 2);
    chk("fmt_ctrl", control_out, 2);
    send(8'h00, 0, 0, 1, 2'd1);
    chk("fmt_count", line_count, 2);
    chk("fmt_lane0", lout[0], 32'h66);
    chk("fmt_lane1", lout[1], 32'h67);
    chk("fmt_sticky", format_err, 1);
    chk("fmt_ctrl2", control_out, 1);
    $display("txn format: format_err=%0d count=%0d", format_err, line_count);

    // randomized traffic, occasional reset
    for (int c = 0; c < 3000; c++) begin
      int nn;
      logic [7:0] m;
      nn = $urandom_range(0, 8);
      m  = ff << (8 - nn);
      if ($urandom_range(0, 9) == 0) m = 8'($urandom);
      for (int i = 0; i < 8; i++) win[i] = $urandom;
      vin = m;
      wiv = ($urandom_range(0, 3) != 0);
      lastin = ($urandom_range(0, 15) == 0);
      ctrl = 2'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      @(posedge clk); #3;
      if (line_valid)
        $display("txn line: count=%0d last=%0d fill=%0d", line_count, line_last, fill_level);
    end
    rst = 0; wiv = 0; lastin = 0;
    repeat (3) @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/update_line_packer.md
# update_line_packer

Downstream of the 8-lane valid-bit sorter in the edge-centric update path. Takes each cycle's sorted 8-word batch, where valid words occupy the highest-indexed lanes, and appends the valid words to a 15-entry accumulator. It emits dense 8-word lines for the memory writer. On end-of-input it flushes a final partial line with a word count and a last flag.

## Interface
Parameters:
- W, 32, payload word width
- LANES, 8, lanes per batch and per output line (fixed at 8; other values unsupported)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- word_in0..word_in7  in  W each  sorted batch words
- valid_in0..valid_in7  in  1 each  per-lane valid
- word_in_valid  in  1  batch qualifier; lanes ignored when 0
- last_input_in  in  1  end-of-input marker, honoured whether or not word_in_valid is 1
- control_in  in  2  partition/control tag, latched on each accepted batch
- line_out0..line_out7  out  W each  packed line, oldest word in lane 0
- line_valid  out  1  one-cycle strobe, line_out*/line_count/line_last valid
- line_count  out  4  valid words in line, 0..8
- line_last  out  1  final line of input
- control_out  out  2  latched control tag accompanying the line
- fill_level  out  4  current accumulator occupancy, 0..7 when idle
- format_err  out  1  sticky: a valid mask was not contiguous at the top
- overflow_err  out  1  sticky: a batch arrived during FLUSH

## Operation
- States: RUN, FLUSH. Reset enters RUN.
- Accept: in RUN with word_in_valid=1, compute n = popcount(valid_in0..7).
  - Lanes 8-n..7 are appended in ascending index order at accumulator positions fill..fill+n-1.
  - Lanes below 8-n are ignored.
- If the valid mask is not exactly the top n lanes, set format_err. Lanes 8-n..7 are still taken.
- Let nf = fill + n (n = 0 when word_in_valid=0); nf is at most 15.
- No last_input_in:
  - nf >= 8: emit acc[0..7] with count 8, last 0. Shift the remainder down; fill = nf-8.
  - nf < 8: no emission; fill = nf.
- last_input_in=1 in RUN:
  - nf <= 8: emit acc[0..nf-1] with count nf, last 1; fill = 0. If nf = 0, emit a zero-count last line.
  - nf >= 9: emit a full line with count 8, last 0, and go to FLUSH with fill = nf-8.
- FLUSH (one cycle only):
  - Emit the remaining fill words with count fill, last 1. Set fill = 0 and return to RUN.
  - word_in_valid=1 in FLUSH: drop the batch and set overflow_err.
  - last_input_in in FLUSH is ignored.
- Lanes at index >= line_count are driven to 0.
- control_out: latched control_in of the most recent accepted batch (or of a last-only cycle). Updated in the same cycle the line registers load.
- Error flags clear only on rst.

## Timing
- All outputs are registered.
- A line is emitted the cycle after the batch that completes it.
  - Batch in cycle t, line_valid in cycle t+1.
  - For the FLUSH case, the final line appears at t+2.
- Throughput: one batch per cycle, at most one line per cycle. The accumulator never exceeds 15, so no backpressure is needed.
- line_valid is a single-cycle strobe. Outputs other than line_valid hold their value between strobes.
- Reset values: line_out* = 0, line_valid = 0, line_count = 0, line_last = 0, control_out = 0, fill_level = 0, format_err = 0, overflow_err = 0, state = RUN, accumulator cleared.
- rst mid-operation discards accumulated words without emitting a line. The first batch after rst release is accepted normally.
- fill_level reflects the post-update occupancy, registered.

## Test plan
- Reset: assert rst with outputs toggling -> all outputs 0 next cycle; fill_level = 0.
- Accumulation:
  - Batches of n = 3, 3, 3 (words 1..9) -> no line after the first two.
  - After the third: line_valid, count 8, line_out0..7 = 1..8, fill_level = 1.
- Full batches: two n = 8 batches back-to-back -> two consecutive lines, each count 8, lanes in input order.
- Flush of 12 words:
  - fill = 5, then a batch with n = 7 and last_input_in -> count 8 / last 0 at t+1.
  - Then count 4 / last 1 at t+2, lanes 4..7 = 0.
  - A batch sent at t+1 -> overflow_err = 1 and the batch is dropped.
- Empty end: last_input_in with word_in_valid = 0 and fill = 0 -> line_valid, count 0, last 1.
- Format: mask valid_in = 0b0101_0000 -> format_err sticky. Words from lanes 6..7 are taken (n = 2); control_out matches control_in.
